mx_phy_port_ctrl_stat: RTL and testbench
========================================

Name: mx_phy_port_ctrl_stat

Overview:
- Parametrised per-port PHY/transceiver control and status block with its own CSR decode, for PORT_CNT ports.
- Drives SFP/PHY control lines and a programmable-width engine reset pulse.
- Synchronises status inputs and latches sticky alarms (write-1-to-clear), with a maskable interrupt and a saturating LOS event counter.
- Sits between the CPU CSR bus and the xgbe port logic.

Parameters:
- PORT_CNT, 2, number of ports (1..16).
- D_WIDTH, 16, CSR data width (multiple of 8, ≥16).
- A_WIDTH, 10, CSR address width (≥ 3 + clog2(PORT_CNT)).
- SYNC_STAGES, 2, synchroniser depth for status inputs (≥1).
- CNT_WIDTH, 16, LOS counter width (≤ D_WIDTH).
- VERSION, 16'h0200, value of the VER register.

Ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- addr_i  in  A_WIDTH  CSR word address.
- wr_en_i  in  1  write strobe.
- wr_data_i  in  D_WIDTH  write data.
- be_i  in  D_WIDTH/8  byte enables for writes.
- rd_en_i  in  1  read strobe.
- rd_data_o  out  D_WIDTH  read data.
- rd_val_o  out  1  read data valid.
- mod_abs_i  in  PORT_CNT  module absent, async.
- rx_los_i  in  PORT_CNT  loss of signal, async.
- tx_fault_i  in  PORT_CNT  transmitter fault, async.
- lopc_i  in  PORT_CNT  loss of optical power, async.
- tx_disable_o  out  PORT_CNT  SFP transmitter disable.
- xge_nreset_o  out  PORT_CNT  10G transceiver reset, active-low.
- gbe_nreset_o  out  PORT_CNT  1G transceiver reset, active-low.
- gbe_coma_o  out  PORT_CNT  1G PHY coma mode.
- tb_gen_pkt_en_o  out  PORT_CNT  test-bench generator enable.
- main_rst_o  out  PORT_CNT  engine reset pulse.
- irq_port_o  out  PORT_CNT  per-port interrupt.
- irq_o  out  1  OR of irq_port_o.

Behaviour:

Address decode:
- port = addr_i[A_WIDTH-1:3], reg = addr_i[2:0].
- port ≥ PORT_CNT: reads return 0, writes are ignored.

Registers (per port):
- 0 CTRL (RW):
  - b0 tx_disable, b1 xge_nreset, b2 gbe_nreset, b3 gbe_coma, b5 tb_gen_pkt_en.
  - b4 main_rst: write-1 triggers a pulse, always reads 0.
  - Reset value 16'h0001: laser off, transceivers held in reset.
- 1 RST_LEN (RW): main_rst pulse length in cycles; 0 is treated as 1. Reset value 16.
- 2 STAT_LIVE (RO): b0 mod_abs, b1 rx_los, b2 tx_fault, b3 lopc, taken from the last synchroniser stage.
- 3 STAT_STICKY (R/W1C): same bit layout as STAT_LIVE. A bit is set on a rising edge of the corresponding synchronised bit. Reset value 0.
- 4 IRQ_MASK (RW): bits 3:0, 1 = enabled. Reset value 0.
- 5 LOS_CNT (RO): counts rx_los rising edges and saturates at all-ones. Any write with any be_i bit set clears it. Reset value 0.
- 6 VER (RO) = VERSION.
- 7: reads 0.
- Unused bits read 0.

Writes and reads:
- Writes honour be_i per byte, including W1C and main_rst (b4 is in byte 0).
- Read latency is 1: rd_val_o = rd_en_i delayed one cycle.
- rd_data_o is registered and holds its value when rd_val_o = 0.
- A simultaneous read and write to the same register returns the pre-write value.

Synchronisation and edges:
- Each status input passes through a SYNC_STAGES flop chain. A change at cycle t is visible in STAT_LIVE at t+SYNC_STAGES.
- A prev register holds the last stage. edge = sync & ~prev. The sticky bit sets, and LOS_CNT increments, at t+SYNC_STAGES+1.
- Reset clears the sync chain and prev to 0. An input held at 1 across reset release therefore produces one sticky event. This is intended, as it reports the initial alarm state.

Simultaneous events:
- Sticky set and W1C on the same bit in the same cycle: set wins.
- LOS edge and LOS_CNT clear in the same cycle: counter becomes 1.
- Edge while the counter is all-ones: counter stays at all-ones.

Interrupts:
- irq_port_o[p] is registered: irq_port_o[p] = |(STICKY & IRQ_MASK), one cycle after sticky/mask update.
- irq_o = registered OR of the per-port terms, so it is coincident with irq_port_o.

Main reset pulse (per-port counter):
- A write with CTRL b4 = 1 loads len = max(RST_LEN, 1), using the RST_LEN value before any same-cycle write.
- main_rst_o is high from the next cycle for exactly len cycles.
- A retrigger while the pulse is active reloads the counter, so the pulse is extended to len cycles from the new write.
- RST_LEN changes during a pulse do not affect it.

Control outputs:
- Outputs are direct register bits, so an update is visible the cycle after the write.

Reset:
- rst_i is synchronous and overrides all activity, including mid-pulse.
- All outputs return to reset values in the cycle after rst_i is sampled high:
  - tx_disable_o = 1.
  - main_rst_o = 0.
  - All other control outputs, irq_o, irq_port_o, rd_val_o and rd_data_o = 0.

Test Plan:
- Reset, then read CTRL/RST_LEN/VER of port 1 (addr 8, 9, 14) -> 16'h0001, 16, 16'h0200 with rd_val_o one cycle after rd_en_i; read of addr 8*PORT_CNT -> 0.
- Pulse:
  - Write RST_LEN = 3, then CTRL = 16'h0010 on port 0 -> main_rst_o[0] high exactly 3 cycles.
  - Retrigger at pulse cycle 2 -> high 5 cycles total.
  - RST_LEN = 0 -> 1-cycle pulse.
  - CTRL reads back with b4 = 0.
- Sticky/irq:
  - IRQ_MASK = 4'h2, pulse rx_los_i[1] high for 1 cycle -> STICKY b1 = 1, LOS_CNT = 1, irq_port_o[1] and irq_o high.
  - Write STICKY 16'h0002 -> irq_o drops after 2 cycles.
  - W1C coincident with a new edge -> bit stays set.
- Byte enables: write CTRL 16'hFF3E with be = 2'b10 -> CTRL unchanged (16'h0001), no pulse; with be = 2'b01 -> 16'h002E and pulse.
- Saturation: CNT_WIDTH = 4, 20 rx_los edges -> LOS_CNT = 15; write plus an edge in the same cycle -> 1.
- Reset mid-operation: assert rst_i during an active pulse and a set STICKY -> main_rst_o = 0, irq_o = 0, tx_disable_o = all ones next cycle; mod_abs_i held 1 -> STICKY b0 = 1 at SYNC_STAGES+1 cycles after release.

Source files
------------

// File: rtl/mx_phy_port_ctrl_stat.sv
// Per-port SFP/PHY control and status block with local CSR decode.
// Each port owns 8 word registers: control, reset pulse length, live/sticky status, irq mask, LOS counter, version.
module mx_phy_port_ctrl_stat #(
  parameter int          PORT_CNT    = 2,
  parameter int          D_WIDTH     = 16,
  parameter int          A_WIDTH     = 10,
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_WIDTH   = 16,
  parameter logic [15:0] VERSION     = 16'h0200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [A_WIDTH-1:0]   addr_i,
  input  logic                 wr_en_i,
  input  logic [D_WIDTH-1:0]   wr_data_i,
  input  logic [D_WIDTH/8-1:0] be_i,
  input  logic                 rd_en_i,
  output logic [D_WIDTH-1:0]   rd_data_o,
  output logic                 rd_val_o,
  input  logic [PORT_CNT-1:0]  mod_abs_i,
  input  logic [PORT_CNT-1:0]  rx_los_i,
  input  logic [PORT_CNT-1:0]  tx_fault_i,
  input  logic [PORT_CNT-1:0]  lopc_i,
  output logic [PORT_CNT-1:0]  tx_disable_o,
  output logic [PORT_CNT-1:0]  xge_nreset_o,
  output logic [PORT_CNT-1:0]  gbe_nreset_o,
  output logic [PORT_CNT-1:0]  gbe_coma_o,
  output logic [PORT_CNT-1:0]  tb_gen_pkt_en_o,
  output logic [PORT_CNT-1:0]  main_rst_o,
  output logic [PORT_CNT-1:0]  irq_port_o,
  output logic                 irq_o
);

  localparam int PW   = A_WIDTH - 3;
  localparam int BE_W = D_WIDTH / 8;

  logic [PW-1:0]           port_idx;
  logic [2:0]              reg_sel;
  logic [D_WIDTH-1:0]      wr_mask;
  logic                    any_be;
  logic [PORT_CNT*D_WIDTH-1:0] rd_flat;
  logic [D_WIDTH-1:0]      rd_mux;
  logic [D_WIDTH-1:0]      rd_data_reg;
  logic                    rd_val_reg;
  logic [PORT_CNT-1:0]     irq_term;
  logic [PORT_CNT-1:0]     irq_port_reg;
  logic                    irq_reg;

  assign port_idx = addr_i[A_WIDTH-1:3];
  assign reg_sel  = addr_i[2:0];
  assign any_be   = |be_i;

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_be
      assign wr_mask[gi*8 +: 8] = {8{be_i[gi]}};
    end
  endgenerate

  generate
    for (gi = 0; gi < PORT_CNT; gi++) begin : g_port
      logic [3:0]           stat_in;
      logic [3:0]           sync_reg [SYNC_STAGES];
      logic [3:0]           prev_reg;
      logic [3:0]           sticky_reg;
      logic [3:0]           mask_reg;
      logic [3:0]           stat_edge;
      logic [3:0]           w1c;
      logic [5:0]           ctrl_reg;
      logic [D_WIDTH-1:0]   rst_len_reg;
      logic [D_WIDTH-1:0]   pulse_cnt_reg;
      logic [D_WIDTH-1:0]   pulse_len;
      logic [CNT_WIDTH-1:0] los_cnt_reg;
      logic                 wr_hit;
      logic                 trig;
      logic                 los_clr;
      logic [D_WIDTH-1:0]   rd_word;

      assign stat_in   = {lopc_i[gi], tx_fault_i[gi], rx_los_i[gi], mod_abs_i[gi]};
      assign wr_hit    = wr_en_i && (port_idx == PW'(gi));
      assign trig      = wr_hit && (reg_sel == 3'd0) && be_i[0] && wr_data_i[4];
      assign los_clr   = wr_hit && (reg_sel == 3'd5) && any_be;
      assign stat_edge = sync_reg[SYNC_STAGES-1] & ~prev_reg;
      assign w1c       = (wr_hit && reg_sel == 3'd3) ? (wr_data_i[3:0] & wr_mask[3:0]) : 4'h0;
      assign pulse_len = (rst_len_reg == '0) ? D_WIDTH'(1) : rst_len_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
          prev_reg      <= '0;
          sticky_reg    <= '0;
          mask_reg      <= '0;
          ctrl_reg      <= 6'h01;
          rst_len_reg   <= D_WIDTH'(16);
          pulse_cnt_reg <= '0;
          los_cnt_reg   <= '0;
        end else begin
          sync_reg[0] <= stat_in;
          for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
          prev_reg <= sync_reg[SYNC_STAGES-1];

          // New edges win over a same-cycle clear.
          sticky_reg <= (sticky_reg & ~w1c) | stat_edge;

          if (wr_hit && reg_sel == 3'd0)
            ctrl_reg <= ((ctrl_reg & ~wr_mask[5:0]) | (wr_data_i[5:0] & wr_mask[5:0])) & 6'b101111;
          if (wr_hit && reg_sel == 3'd1)
            rst_len_reg <= (rst_len_reg & ~wr_mask) | (wr_data_i & wr_mask);
          if (wr_hit && reg_sel == 3'd4)
            mask_reg <= (mask_reg & ~wr_mask[3:0]) | (wr_data_i[3:0] & wr_mask[3:0]);

          if (trig)
            pulse_cnt_reg <= pulse_len;
          else if (pulse_cnt_reg != '0)
            pulse_cnt_reg <= pulse_cnt_reg - D_WIDTH'(1);

          if (stat_edge[1]) begin
            if (los_clr)
              los_cnt_reg <= CNT_WIDTH'(1);
            else if (!(&los_cnt_reg))
              los_cnt_reg <= los_cnt_reg + CNT_WIDTH'(1);
          end else if (los_clr) begin
            los_cnt_reg <= '0;
          end
        end
      end

      always_comb begin
        rd_word = '0;
        case (reg_sel)
          3'd0:    rd_word[5:0]           = ctrl_reg;
          3'd1:    rd_word                = rst_len_reg;
          3'd2:    rd_word[3:0]           = sync_reg[SYNC_STAGES-1];
          3'd3:    rd_word[3:0]           = sticky_reg;
          3'd4:    rd_word[3:0]           = mask_reg;
          3'd5:    rd_word[CNT_WIDTH-1:0] = los_cnt_reg;
          3'd6:    rd_word[15:0]          = VERSION;
          default: rd_word                = '0;
        endcase
      end

      assign rd_flat[gi*D_WIDTH +: D_WIDTH] = rd_word;
      assign irq_term[gi]        = |(sticky_reg & mask_reg);
      assign tx_disable_o[gi]    = ctrl_reg[0];
      assign xge_nreset_o[gi]    = ctrl_reg[1];
      assign gbe_nreset_o[gi]    = ctrl_reg[2];
      assign gbe_coma_o[gi]      = ctrl_reg[3];
      assign tb_gen_pkt_en_o[gi] = ctrl_reg[5];
      assign main_rst_o[gi]      = |pulse_cnt_reg;
    end
  endgenerate

  // Out-of-range ports fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < PORT_CNT; p++)
      if (port_idx == PW'(p)) rd_mux = rd_flat[p*D_WIDTH +: D_WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_val_reg   <= 1'b0;
      rd_data_reg  <= '0;
      irq_port_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      rd_val_reg   <= rd_en_i;
      if (rd_en_i) rd_data_reg <= rd_mux;
      irq_port_reg <= irq_term;
      irq_reg      <= |irq_term;
    end
  end

  assign rd_data_o  = rd_data_reg;
  assign rd_val_o   = rd_val_reg;
  assign irq_port_o = irq_port_reg;
  assign irq_o      = irq_reg;

endmodule

// File: tb/tb_mx_phy_port_ctrl_stat.sv
// Directed bench for mx_phy_port_ctrl_stat: CSR access, reset pulse, sticky/irq, LOS counter, reset behaviour.
module tb_mx_phy_port_ctrl_stat;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [1:0]  be;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_val;
  logic [1:0]  mod_abs, rx_los, tx_fault, lopc;
  logic [1:0]  tx_disable, xge_nreset, gbe_nreset, gbe_coma, tb_gen, main_rst, irq_port;
  logic        irq;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int n, m;

  always #5 clk = ~clk;

  mx_phy_port_ctrl_stat #(
    .PORT_CNT(2), .D_WIDTH(16), .A_WIDTH(10), .SYNC_STAGES(2),
    .CNT_WIDTH(4), .VERSION(16'h0200)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .be_i(be), .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_val_o(rd_val),
    .mod_abs_i(mod_abs), .rx_los_i(rx_los), .tx_fault_i(tx_fault), .lopc_i(lopc),
    .tx_disable_o(tx_disable), .xge_nreset_o(xge_nreset), .gbe_nreset_o(gbe_nreset),
    .gbe_coma_o(gbe_coma), .tb_gen_pkt_en_o(tb_gen), .main_rst_o(main_rst),
    .irq_port_o(irq_port), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
    addr = a; wr_data = d; be = b; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; be = 2'b00;
  endtask

  task automatic csr_read(input string tag, input logic [9:0] a, input logic [15:0] exp);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_val"}, rd_val, 1);
    check(tag, rd_data, exp);
  endtask

  task automatic count_pulse(input int idx, output int cnt);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (main_rst[idx]) cnt++;
      tick();
    end
  endtask

  task automatic los_edge_port1();
    rx_los = 2'b10;
    tick();
    rx_los = 2'b00;
    tick();
  endtask

  initial begin
    rst = 1'b1; addr = '0; wr_en = 1'b0; wr_data = '0; be = '0; rd_en = 1'b0;
    mod_abs = '0; rx_los = '0; tx_fault = '0; lopc = '0;
    repeat (3) tick();

    check("rst_tx_disable", tx_disable, 2'b11);
    check("rst_main_rst", main_rst, 2'b00);
    check("rst_xge_nreset", xge_nreset, 2'b00);
    check("rst_gbe_nreset", gbe_nreset, 2'b00);
    check("rst_coma", gbe_coma, 2'b00);
    check("rst_tb_gen", tb_gen, 2'b00);
    check("rst_irq", irq, 1'b0);
    check("rst_irq_port", irq_port, 2'b00);
    check("rst_rd_val", rd_val, 1'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    rst = 1'b0;
    tick();

    csr_read("ctrl1", 10'd8, 16'h0001);
    csr_read("rstlen1", 10'd9, 16'd16);
    csr_read("ver1", 10'd14, 16'h0200);
    tick();
    check("hold_val", rd_val, 1'b0);
    check("hold_data", rd_data, 16'h0200);
    csr_read("oob_port", 10'd16, 16'h0000);

    // Reset pulse on port 0 with length 3.
    csr_write(10'd1, 16'd3, 2'b11);
    csr_write(10'd0, 16'h0010, 2'b11);
    count_pulse(0, n);
    check("pulse_len3", n, 3);

    // Retrigger during the second pulse cycle.
    n = 0;
    csr_write(10'd0, 16'h0010, 2'b11);
    n += int'(main_rst[0]);
    tick();
    n += int'(main_rst[0]);
    csr_write(10'd0, 16'h0010, 2'b11);
    count_pulse(0, m);
    check("pulse_retrig", n + m, 5);

    csr_write(10'd1, 16'd0, 2'b11);
    csr_write(10'd0, 16'h0010, 2'b11);
    count_pulse(0, n);
    check("pulse_len0", n, 1);
    csr_read("ctrl0_b4", 10'd0, 16'h0000);
    check("ctrl0_txdis", tx_disable, 2'b10);

    // Simultaneous read and write of IRQ_MASK returns the old value.
    addr = 10'd12; wr_data = 16'h0002; be = 2'b11; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; be = 2'b00;
    check("rw_same_cycle", rd_data, 16'h0000);
    csr_read("mask1", 10'd12, 16'h0002);

    // Single-cycle LOS pulse on port 1.
    rx_los = 2'b10;
    tick();
    rx_los = 2'b00;
    repeat (5) tick();
    check("irq_port_set", irq_port, 2'b10);
    check("irq_set", irq, 1'b1);
    csr_read("sticky1", 10'd11, 16'h0002);
    csr_read("loscnt1", 10'd13, 16'h0001);

    csr_write(10'd11, 16'h0002, 2'b11);
    check("irq_after_w1c_1", irq, 1'b1);
    tick();
    check("irq_after_w1c_2", irq, 1'b0);
    check("irq_port_clr", irq_port, 2'b00);

    // W1C lands in the same cycle as a fresh edge.
    rx_los = 2'b10;
    tick();
    rx_los = 2'b00;
    tick();
    csr_write(10'd11, 16'h0002, 2'b11);
    csr_read("sticky_set_wins", 10'd11, 16'h0002);
    csr_read("loscnt2", 10'd13, 16'h0002);

    for (int i = 0; i < 20; i++) los_edge_port1();
    repeat (4) tick();
    csr_read("loscnt_sat", 10'd13, 16'h000F);

    rx_los = 2'b10;
    tick();
    rx_los = 2'b00;
    tick();
    csr_write(10'd13, 16'h0000, 2'b01);
    repeat (3) tick();
    csr_read("loscnt_clr_edge", 10'd13, 16'h0001);
    csr_write(10'd13, 16'h0000, 2'b00);
    csr_read("loscnt_be0", 10'd13, 16'h0001);
    csr_write(10'd13, 16'h0000, 2'b10);
    csr_read("loscnt_clr", 10'd13, 16'h0000);

    // Byte enables on port 1 CTRL.
    csr_write(10'd8, 16'hFF3E, 2'b10);
    check("be_hi_no_pulse", main_rst, 2'b00);
    csr_read("be_hi_ctrl", 10'd8, 16'h0001);
    csr_write(10'd8, 16'hFF3E, 2'b01);
    check("be_lo_pulse", main_rst, 2'b10);
    check("be_lo_txdis", tx_disable, 2'b00);
    check("be_lo_xge", xge_nreset, 2'b10);
    check("be_lo_gbe", gbe_nreset, 2'b10);
    check("be_lo_coma", gbe_coma, 2'b10);
    check("be_lo_tbgen", tb_gen, 2'b10);
    csr_read("be_lo_ctrl", 10'd8, 16'h002E);

    // Reset in the middle of a pulse with a pending interrupt.
    check("pre_rst_pulse", main_rst, 2'b10);
    check("pre_rst_irq", irq, 1'b1);
    mod_abs = 2'b11;
    rst = 1'b1;
    tick();
    check("mid_rst_main", main_rst, 2'b00);
    check("mid_rst_irq", irq, 1'b0);
    check("mid_rst_irq_port", irq_port, 2'b00);
    check("mid_rst_txdis", tx_disable, 2'b11);
    check("mid_rst_xge", xge_nreset, 2'b00);
    tick();
    rst = 1'b0;
    tick();
    tick();
    csr_read("sticky0_early", 10'd3, 16'h0000);
    csr_read("sticky0_set", 10'd3, 16'h0001);
    csr_read("live0", 10'd2, 16'h0001);
    csr_read("ctrl1_after_rst", 10'd8, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
